// File: rtl/line_seg_scheduler_pkg.sv
// Shared types for the line-segment scheduler: coordinate widths,
// the packed segment record and the issue FSM state encoding.
package line_sched_pkg;

  localparam int XW = 11;
  localparam int YW = 10;

  // One draw command, 42 bits, packed {x0, y0, x1, y1}.
  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
  } seg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } sched_state_t;

  // Saturating 16-bit increment for the completed-segment counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/line_seg_scheduler_seg_fifo.sv
// Synchronous FIFO of seg_t records. Read data is the current head
// (combinational from storage); pushes while full and pops while empty
// are dropped.
module seg_fifo
  import line_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  seg_t                     wdata_i,
  input  logic                     pop_i,
  output seg_t                     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  seg_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // Pointer and occupancy next-state; simultaneous push/pop keeps count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Segment storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/line_seg_scheduler.sv
// Line-segment scheduler: round-robin accepts draw commands from NREQ
// shape generators into a FIFO and issues them one at a time to the
// shared Bresenham line engine (start pulse, wait for done).
// Optional macro LINE_SCHED_TIMEOUT_EN adds an engine watchdog that
// abandons a segment after TIMEOUT_CYC cycles in WAIT and sets the
// sticky timeout_err flag.
module line_seg_scheduler
  import line_sched_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*XW-1:0]      req_x0,
  input  logic [NREQ*YW-1:0]      req_y0,
  input  logic [NREQ*XW-1:0]      req_x1,
  input  logic [NREQ*YW-1:0]      req_y1,
  input  logic                    frame_sof,
  output logic                    eng_start,
  output logic [XW-1:0]           eng_x0,
  output logic [YW-1:0]           eng_y0,
  output logic [XW-1:0]           eng_x1,
  output logic [YW-1:0]           eng_y1,
  input  logic                    eng_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             seg_count,
  output logic                    timeout_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_t  state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] gidx_s;
  logic [NREQ-1:0] grant_s;
  logic          push_s, pop_s, done_s, busy_d_s, fifo_drained_s;
  int            idx_v;
  seg_t          push_seg_s, head_seg_s, eng_seg_q;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [15:0]   seg_count_q, seg_count_d;
  logic          eng_start_q, busy_q;

  // Round-robin search starting at rr_ptr; nothing granted while full.
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    push_s  = 1'b0;
    idx_v   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = (int'(rr_ptr_q) + k) % NREQ;
      if (!push_s && !fifo_full_s && req_valid[idx_v]) begin
        grant_s[idx_v] = 1'b1;
        gidx_s         = PW'(idx_v);
        push_s         = 1'b1;
      end else begin
        push_s = push_s;
      end
    end
  end

  assign req_ready = grant_s;

  // Select the granted requester's coordinates and advance the pointer.
  always_comb begin
    push_seg_s.x0 = req_x0[XW*int'(gidx_s) +: XW];
    push_seg_s.y0 = req_y0[YW*int'(gidx_s) +: YW];
    push_seg_s.x1 = req_x1[XW*int'(gidx_s) +: XW];
    push_seg_s.y1 = req_y1[YW*int'(gidx_s) +: YW];
    rr_ptr_d      = rr_ptr_q;
    if (push_s) begin
      rr_ptr_d = (gidx_s == PW'(NREQ - 1)) ? '0 : (gidx_s + PW'(1));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  seg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_s),
    .wdata_i (push_seg_s),
    .pop_i   (pop_s),
    .rdata_o (head_seg_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

`ifdef LINE_SCHED_TIMEOUT_EN
  localparam int WdW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYC - 1);
  logic [WdW-1:0] wd_cnt_q;
  logic           tmo_s, tmo_err_q;
`endif

  // Issue FSM next-state plus seg_count update (frame_sof wins, but a
  // coincident completion still counts as the first of the new frame).
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    done_s      = 1'b0;
    seg_count_d = seg_count_q;
`ifdef LINE_SCHED_TIMEOUT_EN
    tmo_s       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (eng_done) begin
          done_s  = 1'b1;
          state_d = IDLE;
        end
`ifdef LINE_SCHED_TIMEOUT_EN
        else if (wd_cnt_q == WdLimit) begin
          tmo_s   = 1'b1;
          state_d = IDLE;
        end
`endif
        else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_sof) begin
      seg_count_d = done_s ? 16'd1 : 16'd0;
    end else if (done_s) begin
      seg_count_d = sat_inc16(seg_count_q);
    end else begin
      seg_count_d = seg_count_q;
    end
  end

  // Predict next-cycle busy so the output can be registered.
  assign fifo_drained_s = !push_s && ((fifo_count_s == CW'(0)) ||
                                      ((fifo_count_s == CW'(1)) && pop_s));
  assign busy_d_s       = (state_d != IDLE) || !fifo_drained_s;

  // FSM, arbiter pointer and registered engine-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      eng_seg_q   <= '0;
      eng_start_q <= 1'b0;
      seg_count_q <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      eng_start_q <= pop_s;
      seg_count_q <= seg_count_d;
      busy_q      <= busy_d_s;
      if (pop_s) begin
        eng_seg_q <= head_seg_s;
      end
    end
  end

`ifdef LINE_SCHED_TIMEOUT_EN
  // Watchdog: counts WAIT cycles; sticky error cleared only by frame_sof.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q  <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == WAIT && state_d == WAIT) ? (wd_cnt_q + WdW'(1)) : '0;
      if (tmo_s) begin
        tmo_err_q <= 1'b1;
      end else if (frame_sof) begin
        tmo_err_q <= 1'b0;
      end
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign eng_start  = eng_start_q;
  assign eng_x0     = eng_seg_q.x0;
  assign eng_y0     = eng_seg_q.y0;
  assign eng_x1     = eng_seg_q.x1;
  assign eng_y1     = eng_seg_q.y1;
  assign busy       = busy_q;
  assign fifo_count = fifo_count_s;
  assign seg_count  = seg_count_q;

endmodule

// File: tb/tb_line_seg_scheduler.sv
// Directed bench for line_seg_scheduler: a cycle table for single-segment
// issue, round-robin order and simultaneous push/pop, followed by
// hand-written sequences for fairness, FIFO full, reset mid-segment, the
// frame_sof/eng_done race and (with LINE_SCHED_TIMEOUT_EN) the watchdog.
module tb_line_seg_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [21:0] req_x0, req_x1;
  logic [19:0] req_y0, req_y1;
  logic        frame_sof, eng_start, eng_done, busy, timeout_err;
  logic [10:0] eng_x0, eng_x1;
  logic [9:0]  eng_y0, eng_y1;
  logic [4:0]  fifo_count;
  logic [15:0] seg_count;

  int n_checks = 0;
  int n_errors = 0;

  line_seg_scheduler #(.NREQ(2), .DEPTH(16), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .frame_sof(frame_sof), .eng_start(eng_start),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
    .eng_done(eng_done), .busy(busy), .fifo_count(fifo_count),
    .seg_count(seg_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic        done;
    logic        sof;
    logic [1:0]  exp_ready;
    logic        exp_start;
    logic        exp_busy;
    logic [4:0]  exp_fc;
    logic [15:0] exp_sc;
    logic        chk_eng;
    logic [41:0] exp_seg;
  } vec_t;

  vec_t        vecs [19];
  logic [41:0] seg0, seg1;
  logic [10:0] exp_x0 [8];
  int          acc, extra, tk;
  logic [15:0] sc_before;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_one();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      req_valid = 2'b01;
      #1;
      got = req_ready[0];
    end
    @(negedge clk);
    req_valid = 2'b00;
    chk("push_accept", got, 1);
  endtask

  task automatic wait_start();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = eng_start;
    end
    chk("launch_seen", found, 1);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    seg0 = {11'd10, 10'd20, 11'd100, 10'd50};
    seg1 = {11'd7, 10'd7, 11'd7, 10'd7};
    //             valid  done  sof   ready  start busy  fc     sc      eng   seg
    vecs[0]  = '{2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0, 42'd0};
    vecs[1]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd1, 16'd0, 1'b0, 42'd0};
    vecs[2]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 5'd0, 16'd0, 1'b1, seg0};
    vecs[3]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd0, 16'd0, 1'b1, seg0};
    vecs[4]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 16'd1, 1'b0, 42'd0};
    vecs[5]  = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 16'd1, 1'b0, 42'd0};
    vecs[6]  = '{2'b10, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0, 42'd0};
    vecs[7]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd1, 16'd0, 1'b0, 42'd0};
    vecs[8]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 5'd0, 16'd0, 1'b1, seg1};
    vecs[9]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd0, 16'd0, 1'b1, seg1};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 16'd1, 1'b0, 42'd0};
    vecs[11] = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 5'd0, 16'd1, 1'b0, 42'd0};
    vecs[12] = '{2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd1, 16'd1, 1'b0, 42'd0};
    vecs[13] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 5'd1, 16'd1, 1'b1, seg0};
    vecs[14] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd1, 16'd1, 1'b1, seg0};
    vecs[15] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd1, 16'd2, 1'b0, 42'd0};
    vecs[16] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 5'd0, 16'd2, 1'b1, seg1};
    vecs[17] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd0, 16'd2, 1'b0, 42'd0};
    vecs[18] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 16'd3, 1'b0, 42'd0};

    reset_n   = 1'b0;
    req_valid = 2'b00;
    frame_sof = 1'b0;
    eng_done  = 1'b0;
    req_x0 = {11'd7, 11'd10};
    req_y0 = {10'd7, 10'd20};
    req_x1 = {11'd7, 11'd100};
    req_y1 = {10'd7, 10'd50};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_start", eng_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", fifo_count, 0);
    chk("rst_sc", seg_count, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_eng", {eng_x0, eng_y0, eng_x1, eng_y1}, 0);
    reset_n = 1'b1;

    // T1 plus round-robin / simultaneous push-pop table.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk("tbl_start", eng_start, vecs[i].exp_start);
      chk("tbl_busy", busy, vecs[i].exp_busy);
      chk("tbl_fc", fifo_count, vecs[i].exp_fc);
      chk("tbl_sc", seg_count, vecs[i].exp_sc);
      if (vecs[i].chk_eng) chk("tbl_eng", {eng_x0, eng_y0, eng_x1, eng_y1}, vecs[i].exp_seg);
      req_valid = vecs[i].valid;
      eng_done  = vecs[i].done;
      frame_sof = vecs[i].sof;
      #1;
      chk("tbl_ready", req_ready, vecs[i].exp_ready);
    end

    // T2 fairness: both valid, 8 pushes alternate 0,1,0,1...
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = 2'b11;
      req_x0 = {11'(400 + k), 11'(300 + k)};
      #1;
      chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      exp_x0[k] = (k % 2 == 0) ? 11'(300 + k) : 11'(400 + k);
    end
    @(negedge clk);
    req_valid = 2'b00;
    for (int j = 0; j < 8; j++) begin
      chk("rr_engine_order", eng_x0, exp_x0[j]);
      pulse_done();
      if (j < 7) wait_start();
    end
    chk("rr_drained_busy", busy, 0);
    chk("rr_sc", seg_count, 11);

    // T3 full: engine stalled, 1 in flight + 16 queued.
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fifo_count == 5'd16) break;
      req_valid = 2'b01;
      #1;
      if (req_ready[0]) acc++;
    end
    chk("full_fc", fifo_count, 16);
    chk("full_accepted", acc, 17);
    req_valid = 2'b11;
    #1;
    chk("full_ready", req_ready, 2'b00);
    req_valid = 2'b01;
    @(negedge clk);
    eng_done = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      eng_done = 1'b0;
      #1;
      if (req_ready[0]) extra++;
    end
    chk("full_one_more", extra, 1);
    chk("full_fc_again", fifo_count, 16);

    // T5 reset mid-WAIT.
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_fc", fifo_count, 0);
    repeat (3) @(negedge clk);
    chk("midrst_sc", seg_count, 0);
    chk("midrst_eng", {eng_x0, eng_y0, eng_x1, eng_y1}, 0);
    reset_n = 1'b1;
    pulse_done();
    @(negedge clk);
    chk("postrst_sc", seg_count, 0);
    chk("postrst_busy", busy, 0);
    chk("postrst_start", eng_start, 0);

    // T4 frame_sof coincident with eng_done at seg_count 5.
    req_x0 = {11'd7, 11'd10};
    for (int i = 0; i < 5; i++) begin
      push_one();
      wait_start();
      pulse_done();
    end
    chk("sof_pre_sc", seg_count, 5);
    push_one();
    wait_start();
    @(negedge clk);
    eng_done  = 1'b1;
    frame_sof = 1'b1;
    @(negedge clk);
    eng_done  = 1'b0;
    frame_sof = 1'b0;
    chk("sof_race_sc", seg_count, 1);
    chk("sof_race_busy", busy, 0);
    // frame_sof during WAIT leaves the in-flight segment alone.
    push_one();
    wait_start();
    @(negedge clk);
    frame_sof = 1'b1;
    @(negedge clk);
    frame_sof = 1'b0;
    chk("sof_wait_sc", seg_count, 0);
    chk("sof_wait_busy", busy, 1);
    pulse_done();
    chk("sof_wait_done_sc", seg_count, 1);

`ifdef LINE_SCHED_TIMEOUT_EN
    // T6 watchdog: no done, error at WAIT+100, queued segment launches next.
    push_one();
    wait_start();
    sc_before = seg_count;
    tk = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      req_valid = (k == 1) ? 2'b01 : 2'b00;
      if (timeout_err) begin
        tk = k;
        break;
      end
    end
    chk("tmo_cycle", tk, 101);
    chk("tmo_sc", seg_count, sc_before);
    @(negedge clk);
    chk("tmo_next_launch", eng_start, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
